// File: rtl/bubble_rom_arbiter_if.sv
// Requester/ROM bundle for the bubble sprite ROM arbiter.
// slave = arbiter side, master = renderers + ROM side.
interface bubble_rom_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 6
);
  logic                    en;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_address;
  logic [DATA_W-1:0]       rom_q;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    busy;

  modport slave (
    input  en, req, req_addr, rom_q,
    output gnt, rom_address, rvalid, rdata, busy
  );

  modport master (
    output en, req, req_addr, rom_q,
    input  gnt, rom_address, rvalid, rdata, busy
  );
endinterface

// File: rtl/bubble_rom_arbiter.sv
// Round-robin arbiter sharing the bubble sprite ROM read port among N_REQ renderers.
// Returns palette data with a one-hot tag at fixed latency ROM_LAT+1.
module bubble_rom_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned DATA_W  = 6,
  parameter int unsigned ROM_LAT = 1
) (
  input logic                  vga_clk,
  input logic                  reset_n,
  bubble_rom_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]              ptr;
  logic [PTR_W-1:0]              gnt_idx;
  logic [PTR_W-1:0]              cand;
  logic                          found;
  logic [N_REQ-1:0]              gnt_vec;
  logic [ADDR_W-1:0]             addr_sel;
  logic [ADDR_W-1:0]             rom_address_q;
  logic [ROM_LAT:0][N_REQ-1:0]   tag;
  logic [DATA_W-1:0]             rdata_q;
  logic                          busy_q;
  logic                          busy_d;

  // Round-robin search starting at ptr; gnt held low during reset.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt_vec = '0;
    if (reset_n && bus.en) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = PTR_W'((32'(ptr) + k) % N_REQ);
        if (!found && bus.req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (found) gnt_vec[gnt_idx] = 1'b1;
  end

  always_comb begin
    addr_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // busy tracks every stage except the rvalid output stage, registered one edge ahead.
  always_comb begin
    busy_d = |gnt_vec;
    for (int unsigned s = 0; s + 1 < ROM_LAT; s++) begin
      busy_d = busy_d | (|tag[s]);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      rom_address_q <= '0;
      tag           <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      if (found) begin
        rom_address_q <= addr_sel;
        ptr           <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
      tag[0] <= gnt_vec;
      for (int unsigned s = 1; s <= ROM_LAT; s++) begin
        tag[s] <= tag[s-1];
      end
      if (|tag[ROM_LAT-1]) rdata_q <= bus.rom_q;
      busy_q <= busy_d;
    end
  end

  assign bus.gnt         = gnt_vec;
  assign bus.rom_address = rom_address_q;
  assign bus.rvalid      = tag[ROM_LAT];
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bubble_rom_arbiter.sv
// Bench for bubble_rom_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share one stimulus
// and are compared against a grant-list reference model.
module tb_bubble_rom_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 6;

  logic vga_clk = 1'b0;
  logic reset_n;
  always #5 vga_clk = ~vga_clk;

  logic [N-1:0]    req;
  logic            en;
  logic [N*AW-1:0] req_addr;

  bubble_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  bubble_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  assign bus1.req = req;  assign bus1.en = en;  assign bus1.req_addr = req_addr;
  assign bus3.req = req;  assign bus3.en = en;  assign bus3.req_addr = req_addr;

  bubble_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .bus(bus1));
  bubble_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .bus(bus3));

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[DW-1:0];
  endfunction

  // ROM models: sample address on the falling edge, then delay ROM_LAT-1 further cycles.
  logic [DW-1:0] q1;
  logic [DW-1:0] q3 [3];
  always @(negedge vga_clk) begin
    q1    <= rom_f(bus1.rom_address);
    q3[0] <= rom_f(bus3.rom_address);
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign bus1.rom_q = q1;
  assign bus3.rom_q = q3[2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: pointer plus the list of handshaken grants since last reset.
  typedef struct {
    int            cyc;
    int            idx;
    logic [AW-1:0] addr;
  } grant_t;

  grant_t        grants[$];
  int            cyc = 0;
  int            ptr_m = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [N-1:0]  last_gnt = '0;

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] r;
    int           i;
    r = '0;
    if (reset_n && en) begin
      for (int k = 0; k < int'(N); k++) begin
        i = (ptr_m + k) % int'(N);
        if (req[i]) begin
          r[i] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic void exp_ret(input int lat, output logic [N-1:0] v,
                                  output logic [DW-1:0] d, output logic b);
    v = '0; d = '0; b = 1'b0;
    foreach (grants[j]) begin
      if (grants[j].cyc + 1 + lat == cyc) v[grants[j].idx] = 1'b1;
      if (grants[j].cyc + 1 + lat <= cyc) d = rom_f(grants[j].addr);
      if (grants[j].cyc + 1 <= cyc && cyc <= grants[j].cyc + lat) b = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    grants.delete();
    ptr_m    = 0;
    exp_addr = '0;
  endfunction

  task automatic cycle_check();
    logic [N-1:0]  g, v;
    logic [DW-1:0] d;
    logic          b;
    grant_t        gr;
    @(negedge vga_clk);
    g = model_gnt();
    check("gnt_l1", 32'(bus1.gnt), 32'(g));
    check("gnt_l3", 32'(bus3.gnt), 32'(g));
    check("addr_l1", 32'(bus1.rom_address), 32'(exp_addr));
    check("addr_l3", 32'(bus3.rom_address), 32'(exp_addr));
    exp_ret(1, v, d, b);
    check("rvalid_l1", 32'(bus1.rvalid), 32'(v));
    check("rdata_l1", 32'(bus1.rdata), 32'(d));
    check("busy_l1", 32'(bus1.busy), 32'(b));
    exp_ret(3, v, d, b);
    check("rvalid_l3", 32'(bus3.rvalid), 32'(v));
    check("rdata_l3", 32'(bus3.rdata), 32'(d));
    check("busy_l3", 32'(bus3.busy), 32'(b));
    last_gnt = g;
    for (int k = 0; k < int'(N); k++) begin
      if (g[k]) begin
        gr.cyc  = cyc;
        gr.idx  = k;
        gr.addr = req_addr[k*AW +: AW];
        grants.push_back(gr);
        exp_addr = gr.addr;
        ptr_m    = (k + 1) % int'(N);
      end
    end
    cyc++;
  endtask

  task automatic run_fixed(input int n);
    repeat (n) begin
      cycle_check();
      @(posedge vga_clk); #1;
    end
  endtask

  task automatic run_held(input int n);
    repeat (n) begin
      cycle_check();
      @(posedge vga_clk); #1;
      req = req & ~last_gnt;
    end
  endtask

  task automatic reset_zero_check();
    check("rst_gnt_l1", 32'(bus1.gnt), 32'd0);
    check("rst_rvalid_l1", 32'(bus1.rvalid), 32'd0);
    check("rst_busy_l1", 32'(bus1.busy), 32'd0);
    check("rst_addr_l1", 32'(bus1.rom_address), 32'd0);
    check("rst_rdata_l1", 32'(bus1.rdata), 32'd0);
    check("rst_rvalid_l3", 32'(bus3.rvalid), 32'd0);
    check("rst_busy_l3", 32'(bus3.busy), 32'd0);
    check("rst_addr_l3", 32'(bus3.rom_address), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b1;
    en       = 1'b1;
    req      = '1;
    req_addr = {17'h00040, 17'h00030, 17'h00020, 17'h00010};
    #1 reset_n = 1'b0;
    #1 reset_zero_check();
    model_reset();
    run_fixed(2);
    reset_n = 1'b1;

    // All four requesting: rotation 0,1,2,3,0,...
    run_fixed(10);

    // Single requester re-granted back to back.
    req = 4'b0100;
    req_addr[2*AW +: AW] = 17'h12C00;
    run_fixed(3);
    req = '0;
    run_fixed(6);

    // Pointer at 3: lowest index wins next, then wrap from 3 to 0.
    req = 4'b0101;
    run_held(2);
    req = 4'b1000;
    run_held(1);
    req = '0;
    run_fixed(4);

    // Isolated grant to observe ROM_LAT=3 latency and busy window.
    req = 4'b0010;
    req_addr[1*AW +: AW] = 17'h0ABCD;
    run_held(1);
    run_fixed(6);

    // Enable low blocks grants; dropping it mid-stream lets in-flight reads finish.
    en  = 1'b0;
    req = '1;
    run_fixed(6);
    en = 1'b1;
    run_held(2);
    en = 1'b0;
    run_fixed(6);
    en  = 1'b1;
    req = '0;

    // Reset one cycle after a grant discards the in-flight read.
    req = 4'b0010;
    req_addr[1*AW +: AW] = 17'h1F3A5;
    run_held(1);
    reset_n = 1'b0;
    #1 reset_zero_check();
    model_reset();
    run_fixed(2);
    reset_n = 1'b1;
    run_fixed(6);

    // Random traffic: requests held until granted, occasional drops and enable gaps.
    for (int it = 0; it < 500; it++) begin
      cycle_check();
      @(posedge vga_clk); #1;
      for (int i = 0; i < int'(N); i++) begin
        if (req[i] && !last_gnt[i]) begin
          if ($urandom_range(15) == 0) req[i] = 1'b0;
        end else begin
          req[i] = 1'($urandom_range(1));
          if (req[i]) req_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      en = ($urandom_range(7) != 0);
    end

    req = '0;
    run_fixed(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bubble_rom_arbiter.md
Name: bubble_rom_arbiter

Overview:
- Shares the single read port of the bubble sprite ROM (17-bit address, 6-bit palette index, sampled on the falling edge of vga_clk) among N_REQ bubble renderers.
- Each renderer issues single-beat read requests. The arbiter grants one request per cycle in round-robin order, drives the ROM address, and returns the palette index to the granted requester.
- Returned data carries a one-hot valid tag and arrives at fixed latency.
- Sits between the per-bubble draw logic and the bubble ROM / palette lookup.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 17, ROM address width.
- DATA_W, 6, ROM data (palette index) width.
- ROM_LAT, 1, vga_clk cycles from rom_address stable to rom_q capturable at a rising edge (1..3).

Ports:
- vga_clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; 0 = issue no new grants.
- req  input  N_REQ  per-requester read request; held until granted.
- req_addr  input  N_REQ*ADDR_W  packed addresses; slice i belongs to req[i].
- gnt  output  N_REQ  one-hot combinational grant; handshake = req[i]&gnt[i] at a rising edge.
- rom_address  output  ADDR_W  registered address to the ROM.
- rom_q  input  DATA_W  ROM read data.
- rvalid  output  N_REQ  one-hot registered return-valid, one-cycle pulse per grant.
- rdata  output  DATA_W  registered return data, meaningful while any rvalid is set.
- busy  output  1  1 while any granted read is still in flight.

Behaviour:
- Reset (async assert, sync release): round-robin pointer=0, rom_address=0, tag pipeline cleared, rvalid=0, rdata=0, busy=0. gnt=0 while reset_n=0.
- Grant logic (combinational):
  - If en=1 and req!=0, gnt = the first set req bit searching pointer, pointer+1, ... mod N_REQ. Otherwise gnt=0.
  - gnt never has more than one bit set.
  - gnt[i] never asserts without req[i].
- On a rising edge with a grant to i:
  - rom_address <= req_addr slice i.
  - pointer <= (i+1) mod N_REQ.
  - The one-hot tag for i enters the tag pipeline.
- With no grant: rom_address holds its value, pointer holds, and a zero tag enters the pipeline.
- Latency: a grant handshaken at the end of cycle c gives rvalid[i]=1 and rdata=rom_q(req_addr_i) during cycle c+1+ROM_LAT, for exactly one cycle.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants give back-to-back rvalid pulses in grant order.
- Tag pipeline: ROM_LAT+1 stages of N_REQ bits. rvalid is the last stage. rdata captures rom_q at the edge where the second-to-last stage is nonzero; otherwise rdata holds.
- busy = OR of all tag pipeline stages, excluding the rvalid output stage.
- en deasserted mid-stream: no new grants, but in-flight reads complete and return normally.
- Requester drops req before being granted: legal; no grant and no return for it.
- Same requester granted on consecutive cycles (only requester active): allowed; two rvalid pulses.
- Pointer wrap: grant to N_REQ-1 sets pointer to 0.
- Reset asserted mid-operation: all in-flight reads are discarded. No rvalid is emitted for them after reset release.
- req_addr values are passed through unmodified; no range checking.

Test Plan:
- After reset, all req=1 and en=1 with addresses 0x00010, 0x00020, 0x00030, 0x00040 (ROM holding index=addr[5:0]) -> gnt sequence 0,1,2,3,0,...; rvalid 0001,0010,0100,1000 starting 2 cycles after the first grant; rdata 0x10,0x20,0x30,0x00.
- Only req[2]=1 held 3 cycles with addr 0x12C00 -> three consecutive gnt[2]; three consecutive rvalid[2] pulses with rom_q of 0x12C00.
- Pointer at 3, req=0101 -> gnt=0001 first, then 0100. Pointer=3 with req=1000 -> gnt=1000, then pointer=0.
- en=0 with req=1111 -> gnt=0 and rvalid=0 indefinitely. Drop en one cycle after two grants -> both rvalids still delivered, then busy=0.
- ROM_LAT=3 build, single grant at cycle c -> rvalid at c+4 only; busy high cycles c+1..c+3.
- Assert reset_n=0 one cycle after a grant -> rvalid, busy, rom_address go 0 immediately; no rvalid after release.
